hit_damage_ctrl: RTL and testbench



---
 rtl/hit_damage_ctrl_if.sv | 28 ++
 rtl/hit_damage_ctrl.sv | 135 +++++++++++++
 tb/tb_hit_damage_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/hit_damage_ctrl_if.sv
`default_nettype none
// ============================================================================
//  hit_damage_ctrl_if
//  Raster/sprite inputs and health outputs of the hit/damage controller.
//  Revision: 1.0
// ============================================================================
interface hit_damage_ctrl_if;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [11:0] player_pixel_in;
   logic [11:0] hazard_pixel_in;
   logic        damage_out;
   logic [1:0]  health_out;
   logic        invuln_out;
   logic        blink_out;
   logic        game_over_out;

   modport master (
      output hcount_in, vcount_in, player_pixel_in, hazard_pixel_in,
      input  damage_out, health_out, invuln_out, blink_out, game_over_out
   );

   modport slave (
      input  hcount_in, vcount_in, player_pixel_in, hazard_pixel_in,
      output damage_out, health_out, invuln_out, blink_out, game_over_out
   );
endinterface
`default_nettype wire

// File: rtl/hit_damage_ctrl.sv
`default_nettype none
// ============================================================================
//  hit_damage_ctrl
//  Per-frame player/hazard collision to damage pulse, health and i-frames.
//  Revision: 1.0
// ============================================================================
module hit_damage_ctrl #(
   parameter int ACTIVE_H     = 1280,
   parameter int ACTIVE_V     = 720,
   parameter int FRAME_LINE   = 720,
   parameter int MAX_HEALTH   = 3,
   parameter int IFRAMES      = 90,
   parameter int PULSE_CYCLES = 4,
   parameter int BLINK_BIT    = 3
) (
   input  wire logic         clk,
   input  wire logic         rst,
   hit_damage_ctrl_if.slave  bus
);

   localparam logic [10:0] C_ACTIVE_H   = 11'(ACTIVE_H);
   localparam logic [9:0]  C_ACTIVE_V   = 10'(ACTIVE_V);
   localparam logic [9:0]  C_FRAME_LINE = 10'(FRAME_LINE);
   localparam logic [1:0]  C_MAX_HEALTH = 2'(MAX_HEALTH);
   localparam logic [6:0]  C_IFRAMES    = 7'(IFRAMES);
   localparam logic [3:0]  C_PULSE_LOAD = 4'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_ALIVE  = 2'd0,
      ST_INVULN = 2'd1,
      ST_DEAD   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  health_q, health_d;
   logic [6:0]  inv_cnt_q, inv_cnt_d;
   logic [3:0]  pulse_cnt_q, pulse_cnt_d;
   logic        hit_q, hit_d;
   logic        tick_cond_q;
   logic        damage_q, damage_d;
   logic        invuln_q, blink_q, game_over_q;

   logic        w_overlap;
   logic        w_tick_cond;
   logic        w_tick;
   logic        w_pulse_start;

   assign w_overlap = (bus.hcount_in < C_ACTIVE_H) && (bus.vcount_in < C_ACTIVE_V) &&
                      (bus.player_pixel_in != 12'd0) && (bus.hazard_pixel_in != 12'd0);

   // Rising edge of the tick position, so a stalled raster yields a single tick.
   assign w_tick_cond = (bus.hcount_in == 11'd0) && (bus.vcount_in == C_FRAME_LINE);
   assign w_tick      = w_tick_cond && !tick_cond_q;

   // Clear wins over set: the latch restarts empty for the coming frame.
   assign hit_d = w_tick ? 1'b0 : (hit_q | w_overlap);

   always_comb begin
      state_d       = state_q;
      health_d      = health_q;
      inv_cnt_d     = inv_cnt_q;
      w_pulse_start = 1'b0;
      if (w_tick) begin
         case (state_q)
            ST_ALIVE: begin
               if (hit_q) begin
                  w_pulse_start = 1'b1;
                  if (health_q > 2'd1) begin
                     health_d  = health_q - 2'd1;
                     inv_cnt_d = C_IFRAMES;
                     state_d   = ST_INVULN;
                  end else begin
                     health_d  = 2'd0;
                     state_d   = ST_DEAD;
                  end
               end
            end
            ST_INVULN: begin
               inv_cnt_d = inv_cnt_q - 7'd1;
               if (inv_cnt_q == 7'd1) begin
                  state_d = ST_ALIVE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      pulse_cnt_d = 4'd0;
      damage_d    = 1'b0;
      if (w_pulse_start) begin
         pulse_cnt_d = C_PULSE_LOAD;
         damage_d    = 1'b1;
      end else if (pulse_cnt_q != 4'd0) begin
         pulse_cnt_d = pulse_cnt_q - 4'd1;
         damage_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ALIVE;
         health_q    <= C_MAX_HEALTH;
         inv_cnt_q   <= 7'd0;
         pulse_cnt_q <= 4'd0;
         hit_q       <= 1'b0;
         tick_cond_q <= 1'b0;
         damage_q    <= 1'b0;
         invuln_q    <= 1'b0;
         blink_q     <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         health_q    <= health_d;
         inv_cnt_q   <= inv_cnt_d;
         pulse_cnt_q <= pulse_cnt_d;
         hit_q       <= hit_d;
         tick_cond_q <= w_tick_cond;
         damage_q    <= damage_d;
         invuln_q    <= (state_d == ST_INVULN);
         blink_q     <= (state_d == ST_INVULN) && inv_cnt_d[BLINK_BIT];
         game_over_q <= (state_d == ST_DEAD);
      end
   end

   assign bus.damage_out    = damage_q;
   assign bus.health_out    = health_q;
   assign bus.invuln_out    = invuln_q;
   assign bus.blink_out     = blink_q;
   assign bus.game_over_out = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_hit_damage_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_hit_damage_ctrl
//  Directed frame sequence with a behavioural model feeding a scoreboard.
//  Revision: 1.0
// ============================================================================
module tb_hit_damage_ctrl;

   localparam int PULSE = 4;
   localparam int IFR   = 90;
   localparam int MAXH  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hit_damage_ctrl_if bus ();

   hit_damage_ctrl #(
      .ACTIVE_H     (1280),
      .ACTIVE_V     (720),
      .FRAME_LINE   (720),
      .MAX_HEALTH   (MAXH),
      .IFRAMES      (IFR),
      .PULSE_CYCLES (PULSE),
      .BLINK_BIT    (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int health;
      bit invuln;
      bit blink;
      bit game_over;
      int pulse;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   m_state;   // 0 alive, 1 invulnerable, 2 dead
   int   m_health;
   int   m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int h, input int v, input logic [11:0] p, input logic [11:0] z);
      bus.hcount_in       = 11'(h);
      bus.vcount_in       = 10'(v);
      bus.player_pixel_in = p;
      bus.hazard_pixel_in = z;
   endtask

   task automatic model_reset();
      m_state  = 0;
      m_health = MAXH;
      m_cnt    = 0;
      sb.delete();
   endtask

   task automatic model_tick(input bit latch);
      exp_t e;
      e.pulse = 0;
      case (m_state)
         0: if (latch) begin
               e.pulse = PULSE;
               if (m_health > 1) begin
                  m_health--;
                  m_cnt   = IFR;
                  m_state = 1;
               end else begin
                  m_health = 0;
                  m_state  = 2;
               end
            end
         1: begin
               if (m_cnt == 1) m_state = 0;
               m_cnt--;
            end
         default: ;
      endcase
      e.health    = m_health;
      e.invuln    = (m_state == 1);
      e.blink     = (m_state == 1) && m_cnt[3];
      e.game_over = (m_state == 2);
      sb.push_back(e);
   endtask

   task automatic check_outputs(input exp_t e);
      chk("health",    32'(bus.health_out),    32'(e.health));
      chk("invuln",    32'(bus.invuln_out),    32'(e.invuln));
      chk("blink",     32'(bus.blink_out),     32'(e.blink));
      chk("game_over", 32'(bus.game_over_out), 32'(e.game_over));
   endtask

   // One compressed frame: lone-sprite pixels, optional overlap pixel, then the tick.
   task automatic frame(input bit ovl, input int ox, input int oy, input bit stall);
      exp_t e;
      int   dmg_cnt;
      drive(10, 10, 12'hF00, 12'h000); step();
      drive(20, 10, 12'h000, 12'h0F0); step();
      if (ovl) begin
         drive(ox, oy, 12'h123, 12'h456); step();
      end
      drive(5, 5, 12'h000, 12'h000); step();
      drive(0, 720, 12'h000, 12'h000);
      model_tick(ovl && ox < 1280 && oy < 720);
      step();
      e = sb.pop_front();
      check_outputs(e);
      chk("dmg_rise", 32'(bus.damage_out), 32'(e.pulse != 0));
      dmg_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         if (bus.damage_out === 1'b1) dmg_cnt++;
         drive((stall && i < 2) ? 0 : i + 1, 720, 12'h000, 12'h000);
         step();
      end
      chk("pulse_len", 32'(dmg_cnt), 32'(e.pulse));
   endtask

   initial begin
      exp_t e;
      rst = 1'b1;
      drive(0, 0, 12'h000, 12'h000);
      model_reset();
      step(); step();
      chk("rst_damage", 32'(bus.damage_out), 32'd0);
      e = '{health: MAXH, invuln: 0, blink: 0, game_over: 0, pulse: 0};
      check_outputs(e);
      rst = 1'b0;

      for (int f = 0; f < 3; f++) frame(1'b0, 0, 0, 1'b0);
      frame(1'b1, 1280, 100, 1'b0);
      frame(1'b1, 100, 720, 1'b0);
      frame(1'b1, 2000, 5, 1'b0);

      frame(1'b1, 100, 100, 1'b0);
      for (int f = 0; f < 95; f++) frame(1'b1, 100 + f, 100, (f % 10) == 3);

      for (int f = 0; f < 90; f++) frame(1'b0, 0, 0, (f % 7) == 2);
      frame(1'b1, 1279, 719, 1'b0);
      for (int f = 0; f < 3; f++) frame(1'b1, 300, 300, 1'b0);

      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      frame(1'b0, 0, 0, 1'b0);
      drive(100, 100, 12'h123, 12'h456); step();
      drive(5, 5, 12'h000, 12'h000); step();
      drive(0, 720, 12'h000, 12'h000);
      model_tick(1'b1);
      step();
      e = sb.pop_front();
      chk("mid_dmg_t1", 32'(bus.damage_out), 32'd1);
      chk("mid_health", 32'(bus.health_out), 32'(e.health));
      drive(1, 720, 12'h000, 12'h000); step();
      chk("mid_dmg_t2", 32'(bus.damage_out), 32'd1);
      rst = 1'b1;
      step();
      chk("rst_mid_damage", 32'(bus.damage_out), 32'd0);
      e = '{health: MAXH, invuln: 0, blink: 0, game_over: 0, pulse: 0};
      check_outputs(e);
      rst = 1'b0;
      model_reset();
      frame(1'b0, 0, 0, 1'b0);
      frame(1'b1, 640, 360, 1'b0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
